// File: rtl/csela_share_ctrl_pkg.sv
// csela_ctrl_pkg: shared types and helpers for the carry-select adder share controller
//   state_t     : controller phase, IDLE -> EXEC -> RESP
//   NUM_REQ_MAX : largest supported requester count
//   idx_w()     : width of a requester index (at least one bit)
package csela_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int NUM_REQ_MAX = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csela_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at/after ptr
//   req : request vector
//   ptr : highest-priority requester index (must be < N)
//   gnt : one-hot grant, all zero when nothing requests
//   idx : index of the granted requester
//   any : at least one request present
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Walk the circle farthest-first so the candidate nearest ptr wins last.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

    assign gnt = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/csela_share_ctrl.sv
// csela_share_ctrl: shares one external carry-select adder among NUM_REQ requesters
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/ready/a/b/sub      : per-requester operation channel (ready is one-hot)
//   rsp_valid/ready, rsp_sum/cout/ovf : per-requester result channel (valid is one-hot)
//   add_a/add_b/add_cin          : registered operands driven to the adder
//   add_sum/add_cout/add_ovf     : combinational adder results
//   busy                         : an operation is in flight
//   op_count                     : completed responses, wrapping
module csela_share_ctrl
    import csela_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_cout,
    input  logic                     add_ovf,
    output logic                     busy,
    output logic [CNT_W-1:0]         op_count
);

    localparam int IW = idx_w(NUM_REQ);

    state_t        state, state_nxt;
    logic [IW-1:0] rr_ptr, owner, g_idx;
    logic [NUM_REQ-1:0] g_vec;
    logic          g_any, accept, hs;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic          sub_sel;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (g_vec),
        .idx (g_idx),
        .any (g_any)
    );

    assign a_sel   = req_a[int'(g_idx)*WIDTH +: WIDTH];
    assign b_sel   = req_b[int'(g_idx)*WIDTH +: WIDTH];
    assign sub_sel = req_sub[g_idx];
    assign accept  = (state == IDLE) && g_any;
    // Only the owner's rsp_ready can complete the response.
    assign hs      = (state == RESP) && rsp_ready[owner];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = g_any ? EXEC : IDLE;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = hs ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) ? g_vec : '0;
        rsp_valid = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
        busy      = (state != IDLE);
    end

    // Subtraction is a + ~b + 1, so the adder sees inverted b and cin=1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            owner    <= '0;
            add_a    <= '0;
            add_b    <= '0;
            add_cin  <= 1'b0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_ovf  <= 1'b0;
            op_count <= '0;
        end else begin
            if (accept) begin
                owner   <= g_idx;
                add_a   <= a_sel;
                add_b   <= sub_sel ? ~b_sel : b_sel;
                add_cin <= sub_sel;
            end
            if (state == EXEC) begin
                rsp_sum  <= add_sum;
                rsp_cout <= add_cout;
                rsp_ovf  <= add_ovf;
            end
            if (hs) begin
                rr_ptr   <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule
